// File: rtl/calc_sequencer.sv
// calc_sequencer: operand capture and operation sequencing for the calculator.
// Captures A and B from the switches on Enter, then runs add/sub in one cycle
// or mul/div through a 16-step iterative engine. All outputs are registered.
module calc_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       op_sel,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    S_GET_A   = 2'b00,
    S_GET_B   = 2'b01,
    S_COMPUTE = 2'b10,
    S_SHOW_C  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  state_t             state_q;
  op_t                op_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, c_q;
  logic               busy_q, done_q, ovf_q;
  // mul: acc_q accumulates, mcand_q is A shifted left, work_q is B shifted right
  // div: work_q holds the dividend shifting out / quotient shifting in, rem_q the remainder
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH:0]     rem_q;

  logic [WIDTH:0]     sum_d;
  logic [WIDTH-1:0]   diff_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic               last_d;
  logic               div_zero;

  // Single-cycle datapath results and one iteration step of the mul/div engine
  always_comb begin
    sum_d    = {1'b0, a_q} + {1'b0, b_q};
    diff_d   = a_q - b_q;
    acc_d    = acc_q + (work_q[0] ? mcand_q : '0);
    rem_sh   = {rem_q[WIDTH-1:0], work_q[WIDTH-1]};
    rem_d    = rem_sh;
    quo_d    = {work_q[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, b_q}) begin
      rem_d = rem_sh - {1'b0, b_q};
      quo_d = {work_q[WIDTH-2:0], 1'b1};
    end
    last_d   = (cnt_q == LAST);
    div_zero = (b_q == '0);
  end

  // Sequencer FSM with registered outputs; clear overrides everything else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GET_A;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      work_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (btn_clear) begin
        state_q <= S_GET_A;
        cnt_q   <= '0;
        a_q     <= '0;
        b_q     <= '0;
        c_q     <= '0;
        busy_q  <= 1'b0;
        ovf_q   <= 1'b0;
        acc_q   <= '0;
        mcand_q <= '0;
        work_q  <= '0;
        rem_q   <= '0;
      end else begin
        unique case (state_q)
          S_GET_A: begin
            if (btn_enter) begin
              a_q     <= sw;
              state_q <= S_GET_B;
            end
          end
          S_GET_B: begin
            if (btn_enter) begin
              b_q     <= sw;
              op_q    <= op_t'(op_sel);
              cnt_q   <= '0;
              acc_q   <= '0;
              mcand_q <= {{WIDTH{1'b0}}, a_q};
              work_q  <= (op_t'(op_sel) == OP_MUL) ? sw : a_q;
              rem_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            unique case (op_q)
              OP_ADD: begin
                c_q     <= sum_d[WIDTH-1:0];
                ovf_q   <= sum_d[WIDTH];
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_SHOW_C;
              end
              OP_SUB: begin
                c_q     <= diff_d;
                ovf_q   <= (a_q < b_q);
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_SHOW_C;
              end
              OP_MUL: begin
                acc_q   <= acc_d;
                mcand_q <= mcand_q << 1;
                work_q  <= work_q >> 1;
                cnt_q   <= cnt_q + CW'(1);
                if (last_d) begin
                  c_q     <= acc_d[WIDTH-1:0];
                  ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_SHOW_C;
                end
              end
              OP_DIV: begin
                // divide-by-zero only burns cycles so timing matches a real divide
                cnt_q <= cnt_q + CW'(1);
                if (!div_zero) begin
                  work_q <= quo_d;
                  rem_q  <= rem_d;
                end
                if (last_d) begin
                  c_q     <= div_zero ? '1 : quo_d;
                  ovf_q   <= div_zero;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_SHOW_C;
                end
              end
              default: ;
            endcase
          end
          S_SHOW_C: begin
            if (btn_enter) begin
              a_q     <= c_q;
              b_q     <= '0;
              ovf_q   <= 1'b0;
              state_q <= S_GET_B;
            end
          end
          default: state_q <= S_GET_A;
        endcase
      end
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign C     = c_q;
  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed-vector bench for calc_sequencer with hand-computed expectations.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [1:0]  op_sel;
  logic        btn_enter;
  logic        btn_clear;
  logic [15:0] A, B, C;
  logic [1:0]  state;
  logic        busy, done, ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  calc_sequencer #(.WIDTH(16), .ITERS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .op_sel    (op_sel),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .A         (A),
    .B         (B),
    .C         (C),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // inputs change on negedge, DUT samples on the following posedge
  task automatic press(input logic [15:0] v, input logic [1:0] op);
    sw        = v;
    op_sel    = op;
    btn_enter = 1'b1;
    @(negedge clk);
    btn_enter = 1'b0;
  endtask

  task automatic clear_all();
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_A", 32'(A), 32'd0);
    check("clr_B", 32'(B), 32'd0);
    check("clr_C", 32'(C), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
  endtask

  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [15:0] exp_c, input logic exp_o,
                       input int unsigned lat, input bit poke);
    int unsigned bc;
    int unsigned k;
    press(a, 2'b00);
    check({nm, "_stB"}, 32'(state), 32'd1);
    check({nm, "_A"}, 32'(A), 32'(a));
    press(b, op);
    check({nm, "_stC"}, 32'(state), 32'd2);
    check({nm, "_B"}, 32'(B), 32'(b));
    bc = 0;
    k  = 0;
    while (!done && k < 40) begin
      if (busy) bc++;
      btn_enter = poke && (k % 2 == 0);
      op_sel    = ~op;
      k++;
      @(negedge clk);
    end
    btn_enter = 1'b0;
    check({nm, "_lat"}, bc, lat);
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_stS"}, 32'(state), 32'd3);
    check({nm, "_C"}, 32'(C), 32'(exp_c));
    check({nm, "_ovf"}, 32'(ovf), 32'(exp_o));
    @(negedge clk);
    check({nm, "_done1"}, 32'(done), 32'd0);
    check({nm, "_Chold"}, 32'(C), 32'(exp_c));
  endtask

  initial begin
    rst = 1'b1; sw = '0; op_sel = '0; btn_enter = 1'b0; btn_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ABC", {A, B}, 32'd0);
    check("rst_C", 32'(C), 32'd0);
    check("rst_flags", {29'd0, busy, done, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // add, then chain
    do_op("add1", 16'h0003, 16'h0005, 2'b00, 16'h0008, 1'b0, 1, 1'b0);
    press(16'h0000, 2'b00);
    check("chain_state", 32'(state), 32'd1);
    check("chain_A", 32'(A), 32'h0008);
    check("chain_B", 32'(B), 32'h0000);
    check("chain_C", 32'(C), 32'h0008);
    check("chain_ovf", 32'(ovf), 32'd0);
    press(16'h0002, 2'b00);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("chain_res", 32'(C), 32'h000A);
    check("chain_done", 32'(done), 32'd1);
    clear_all();

    do_op("add2", 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1, 1'b0);
    clear_all();
    do_op("sub1", 16'h0002, 16'h0005, 2'b01, 16'hFFFD, 1'b1, 1, 1'b0);
    clear_all();
    do_op("sub2", 16'h0010, 16'h0003, 2'b01, 16'h000D, 1'b0, 1, 1'b0);
    clear_all();
    do_op("mul1", 16'h00FF, 16'h0101, 2'b10, 16'hFFFF, 1'b0, 16, 1'b0);
    clear_all();
    do_op("mul2", 16'h0100, 16'h0100, 2'b10, 16'h0000, 1'b1, 16, 1'b0);
    clear_all();
    do_op("mul3", 16'h1234, 16'h0003, 2'b10, 16'h369C, 1'b0, 16, 1'b0);
    clear_all();
    do_op("mulpk", 16'h00FF, 16'h0101, 2'b10, 16'hFFFF, 1'b0, 16, 1'b1);
    clear_all();
    do_op("div1", 16'h0064, 16'h0007, 2'b11, 16'h000E, 1'b0, 16, 1'b0);
    clear_all();
    do_op("div0", 16'h0064, 16'h0000, 2'b11, 16'hFFFF, 1'b1, 16, 1'b0);
    clear_all();
    do_op("div2", 16'hFFFF, 16'h0010, 2'b11, 16'h0FFF, 1'b0, 16, 1'b1);
    clear_all();

    // clear and enter together in GET_B
    press(16'h0042, 2'b00);
    check("ce_pre", 32'(state), 32'd1);
    sw = 16'h0011; btn_enter = 1'b1; btn_clear = 1'b1;
    @(negedge clk);
    btn_enter = 1'b0; btn_clear = 1'b0;
    check("ce_state", 32'(state), 32'd0);
    check("ce_AB", {A, B}, 32'd0);
    check("ce_C", 32'(C), 32'd0);

    // clear mid-compute abandons the multiply
    press(16'h0005, 2'b00);
    press(16'h0005, 2'b10);
    repeat (4) @(negedge clk);
    clear_all();
    repeat (20) @(negedge clk);
    check("cmid_state", 32'(state), 32'd0);
    check("cmid_done", 32'(done), 32'd0);

    // asynchronous reset during multiply iteration 7
    press(16'h00FF, 2'b00);
    press(16'h0101, 2'b10);
    repeat (6) @(negedge clk);
    check("rmid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rmid_state", 32'(state), 32'd0);
    check("rmid_AB", {A, B}, 32'd0);
    check("rmid_C", 32'(C), 32'd0);
    check("rmid_flags", {29'd0, busy, done, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rpost_state", 32'(state), 32'd0);
    check("rpost_C", 32'(C), 32'd0);
    do_op("addr", 16'h1000, 16'h0234, 2'b00, 16'h1234, 1'b0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Sequences the Simple Calculator datapath: captures operand A and operand B from the board switches on Enter presses, then runs the selected operation.
- Add/sub complete in one cycle; mul/div use an iterative 16-step engine.
- Drives the A/B/C values that the VGA text renderer displays, plus status to the LEDs/top level.
- Sits between the debounced button/switch inputs and calculator_output.

Parameters:
- WIDTH, 16, operand/result width; must stay 16 to match the display fields.
- ITERS, 16, mul/div iteration count; equals WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw  in  WIDTH  operand switches
- op_sel  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- btn_enter  in  1  debounced, single-cycle Enter pulse
- btn_clear  in  1  debounced, single-cycle Clear pulse
- A  out  WIDTH  operand A to display
- B  out  WIDTH  operand B to display
- C  out  WIDTH  result to display
- state  out  2  00 GET_A, 01 GET_B, 10 COMPUTE, 11 SHOW_C
- busy  out  1  high while in COMPUTE
- done  out  1  one-cycle pulse on the cycle SHOW_C is entered
- ovf  out  1  result overflow/error flag, valid in SHOW_C

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst). While rst=1: state=GET_A; A, B, C = 0; busy, done, ovf = 0; internal counter and accumulators = 0.
- Reset mid-COMPUTE aborts the operation. No partial result is kept.

State transitions (all outputs registered):
- GET_A, btn_enter: A<=sw; go to GET_B.
- GET_B, btn_enter: B<=sw; op latched internally from op_sel; iteration counter<=0; go to COMPUTE. op_sel changes after this point are ignored until the next capture.
- COMPUTE, add: C<=A+B (low 16 bits); ovf<=carry out; go to SHOW_C.
- COMPUTE, sub: C<=A-B mod 2^16; ovf<=(A<B) unsigned; go to SHOW_C.
- COMPUTE, mul: shift-add, one multiplier bit per cycle, LSB first, into a 32-bit accumulator. After ITERS cycles (counter==ITERS-1): C<=acc[15:0]; ovf<=|acc[31:16]; go to SHOW_C.
- COMPUTE, div: restoring division, one quotient bit per cycle, MSB first. After ITERS cycles: C<=quotient; remainder discarded; ovf<=0.
- COMPUTE, div with B==0: no iterations still takes ITERS cycles. Result C=16'hFFFF, ovf=1.
- SHOW_C, btn_enter: chaining. A<=C; B<=0; ovf<=0; go to GET_B.

Clear, enter and done rules:
- btn_clear in any state, including COMPUTE: next cycle state=GET_A; A, B, C = 0; ovf=0; any operation in flight is abandoned.
- btn_clear and btn_enter in the same cycle: clear wins.
- btn_enter in COMPUTE is ignored and not queued.
- done=1 exactly on the first SHOW_C cycle, 0 otherwise.
- busy = (state==COMPUTE).

Latency (Enter sampled in GET_B at edge n):
- COMPUTE visible after edge n.
- add/sub: C, ovf and done valid after edge n+1.
- mul/div: C, ovf and done valid after edge n+ITERS (n+16).

Arithmetic:
- All arithmetic is unsigned.
- C holds its value until the next result, a chain Enter (C retained, A<=C), clear, or reset.

Test Plan:
- Add: Enter sw=0x0003, Enter sw=0x0005 with op=00 -> state COMPUTE for 1 cycle; then C=0x0008, ovf=0, done pulses once. Repeat with 0xFFFF+0x0001 -> C=0x0000, ovf=1.
- Sub: A=0x0002, B=0x0005, op=01 -> C=0xFFFD, ovf=1. A=0x0010, B=0x0003 -> C=0x000D, ovf=0.
- Mul: A=0x00FF, B=0x0101, op=10 -> busy high exactly 16 cycles; then C=0xFFFF, ovf=0. A=0x0100, B=0x0100 -> C=0x0000, ovf=1.
- Div: A=0x0064, B=0x0007, op=11 -> after 16 cycles C=0x000E, ovf=0. B=0x0000 -> C=0xFFFF, ovf=1.
- Chaining and ignore: after C=0x0008, Enter -> A=0x0008, state GET_B. Enter pulses during a mul COMPUTE -> no effect; result and timing unchanged.
- Clear/reset priority: clear+enter in the same GET_B cycle -> GET_A with A=B=C=0. Assert rst at mul iteration 7 -> all outputs 0 immediately, asynchronously. After release, a new add completes correctly.
